// File: rtl/led_row_shift_driver.sv
// led_row_shift_driver
//   Takes one parallel row word per valid/ready handshake and shifts it
//   MSB-first into the panel's serial column chain using a divided shift
//   clock. After the last bit the panel is blanked, the storage latch is
//   strobed and the row address advances. The previously latched row stays
//   lit while the next one shifts in.
//
// Ports
//   clk          system clock, rising edge
//   CLR          asynchronous active-low reset
//   pix_data     row word, bit COLS-1 shifted first
//   pix_valid    producer has a word (held until accepted)
//   pix_ready    driver idle, word accepted when pix_valid & pix_ready
//   ser_d        serial data to chain D input
//   ser_clk      shift clock to chain
//   latch        storage-register latch strobe, active high
//   n_oe         panel output enable, active low (1 = blanked)
//   row_addr     row currently displayed
//   frame_start  one-cycle pulse after row_addr wraps to 0
module led_row_shift_driver #(
   parameter int COLS    = 16,
   parameter int ROWS    = 8,
   parameter int CLK_DIV = 2
) (
   input  logic                                        clk,
   input  logic                                        CLR,
   input  logic [COLS-1:0]                             pix_data,
   input  logic                                        pix_valid,
   output logic                                        pix_ready,
   output logic                                        ser_d,
   output logic                                        ser_clk,
   output logic                                        latch,
   output logic                                        n_oe,
   output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0]  row_addr,
   output logic                                        frame_start
);

   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BW = (COLS > 1) ? $clog2(COLS) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(COLS - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] BLANK = 2'd2;
   localparam logic [1:0] LATCH = 2'd3;

   logic [1:0]      state;
   logic [DW-1:0]   div_cnt;
   logic [BW-1:0]   bit_cnt;
   // Holds only the bits still to be sent; the MSB goes straight to ser_d
   // on the accept edge.
   logic [COLS-2:0] shreg;

   always_ff @(posedge clk or negedge CLR) begin
      if (!CLR) begin
         state       <= IDLE;
         div_cnt     <= '0;
         bit_cnt     <= '0;
         shreg       <= '0;
         pix_ready   <= 1'b0;
         ser_d       <= 1'b0;
         ser_clk     <= 1'b0;
         latch       <= 1'b0;
         n_oe        <= 1'b1;
         row_addr    <= '0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         case (state)
            IDLE: begin
               ser_clk <= 1'b0;
               latch   <= 1'b0;
               if (pix_valid && pix_ready) begin
                  // Accept edge also opens the first low phase.
                  state     <= SHIFT;
                  pix_ready <= 1'b0;
                  shreg     <= pix_data[COLS-2:0];
                  ser_d     <= pix_data[COLS-1];
                  div_cnt   <= '0;
                  bit_cnt   <= '0;
               end else begin
                  pix_ready <= 1'b1;
               end
            end

            SHIFT: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  if (!ser_clk) begin
                     ser_clk <= 1'b1;
                  end else if (bit_cnt == BIT_LAST) begin
                     ser_clk <= 1'b0;
                     ser_d   <= 1'b0;
                     n_oe    <= 1'b1;
                     state   <= BLANK;
                  end else begin
                     // ser_d only moves here, at the start of a low phase.
                     ser_clk <= 1'b0;
                     ser_d   <= shreg[COLS-2];
                     shreg   <= shreg << 1;
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end

            BLANK: begin
               state   <= LATCH;
               latch   <= 1'b1;
               div_cnt <= '0;
            end

            LATCH: begin
               if (div_cnt == DIV_LAST) begin
                  latch     <= 1'b0;
                  n_oe      <= 1'b0;
                  pix_ready <= 1'b1;
                  div_cnt   <= '0;
                  state     <= IDLE;
                  if (row_addr == ROW_LAST) begin
                     row_addr    <= '0;
                     frame_start <= 1'b1;
                  end else begin
                     row_addr <= row_addr + 1'b1;
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_led_row_shift_driver.sv
// tb_led_row_shift_driver
//   Directed bench for led_row_shift_driver. Instance a uses CLK_DIV=1,
//   instance b uses CLK_DIV=3; both COLS=4, ROWS=8. A four-stage D flip-flop
//   chain clocked by ser_clk models the panel columns; latched words are
//   compared against a queue of words pushed when offered.
module tb_led_row_shift_driver;

   localparam int COLS = 4;
   localparam int ROWS = 8;

   logic       clk = 1'b0;
   logic       CLR = 1'b0;

   logic [3:0] a_pix_data = '0;
   logic       a_pix_valid = 1'b0;
   logic       a_pix_ready, a_ser_d, a_ser_clk, a_latch, a_n_oe, a_frame_start;
   logic [2:0] a_row_addr;

   logic [3:0] b_pix_data = '0;
   logic       b_pix_valid = 1'b0;
   logic       b_pix_ready, b_ser_d, b_ser_clk, b_latch, b_n_oe, b_frame_start;
   logic [2:0] b_row_addr;

   always #5 clk = ~clk;

   led_row_shift_driver #(.COLS(COLS), .ROWS(ROWS), .CLK_DIV(1)) u_a (
      .clk(clk), .CLR(CLR), .pix_data(a_pix_data), .pix_valid(a_pix_valid),
      .pix_ready(a_pix_ready), .ser_d(a_ser_d), .ser_clk(a_ser_clk),
      .latch(a_latch), .n_oe(a_n_oe), .row_addr(a_row_addr),
      .frame_start(a_frame_start)
   );

   led_row_shift_driver #(.COLS(COLS), .ROWS(ROWS), .CLK_DIV(3)) u_b (
      .clk(clk), .CLR(CLR), .pix_data(b_pix_data), .pix_valid(b_pix_valid),
      .pix_ready(b_pix_ready), .ser_d(b_ser_d), .ser_clk(b_ser_clk),
      .latch(b_latch), .n_oe(b_n_oe), .row_addr(b_row_addr),
      .frame_start(b_frame_start)
   );

   // Column chain: first bit shifted ends up in the top stage.
   logic [3:0] chain_a = '0;
   logic [3:0] chain_b = '0;
   always @(posedge a_ser_clk) chain_a <= {chain_a[2:0], a_ser_d};
   always @(posedge b_ser_clk) chain_b <= {chain_b[2:0], b_ser_d};

   int n_tests = 0;
   int n_fail  = 0;

   logic [3:0] q_a[$];
   logic [3:0] sb_exp;

   int w_cyc, w_hi, w_noe, w_lat, w_fs, w_hmin, w_hmax;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Steps until pix_ready is seen high, tallying what the outputs did.
   task automatic wait_ready(input bit use_b);
      int   run;
      logic sc, rdy;
      w_cyc = 0; w_hi = 0; w_noe = 0; w_lat = 0; w_fs = 0;
      w_hmin = 1000; w_hmax = 0; run = 0; rdy = 1'b0;
      while (!rdy && w_cyc < 200) begin
         tick();
         w_cyc++;
         sc  = use_b ? b_ser_clk : a_ser_clk;
         rdy = use_b ? b_pix_ready : a_pix_ready;
         if (sc) begin
            w_hi++;
            run++;
         end else if (run > 0) begin
            if (run < w_hmin) w_hmin = run;
            if (run > w_hmax) w_hmax = run;
            run = 0;
         end
         if (use_b ? b_n_oe : a_n_oe) w_noe++;
         if (use_b ? b_latch : a_latch) w_lat++;
         if (use_b ? b_frame_start : a_frame_start) w_fs++;
      end
      check("ready_timeout", 32'(rdy), 1);
   endtask

   // Scoreboard: each latch strobe must match the oldest offered word.
   always @(posedge a_latch) begin
      #1;
      check("sb_pending", 32'(q_a.size() != 0), 1);
      if (q_a.size() != 0) begin
         sb_exp = q_a.pop_front();
         check("sb_chain_a", 32'(chain_a), 32'(sb_exp));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cnt;
      logic prev;

      // ---- 1: reset / idle
      repeat (3) tick();
      check("rst_ser_clk", 32'(a_ser_clk), 0);
      check("rst_ser_d",   32'(a_ser_d), 0);
      check("rst_latch",   32'(a_latch), 0);
      check("rst_n_oe",    32'(a_n_oe), 1);
      check("rst_row",     32'(a_row_addr), 0);
      check("rst_ready",   32'(a_pix_ready), 0);
      check("rst_fs",      32'(a_frame_start), 0);
      check("rst_ready_b", 32'(b_pix_ready), 0);
      CLR = 1'b1;
      tick();
      check("rel_ready",   32'(a_pix_ready), 1);
      check("rel_ready_b", 32'(b_pix_ready), 1);
      repeat (3) tick();
      check("idle_n_oe",    32'(a_n_oe), 1);
      check("idle_ser_clk", 32'(a_ser_clk), 0);

      // ---- 2: single row, CLK_DIV=1
      a_pix_data = 4'b1011; a_pix_valid = 1'b1; q_a.push_back(4'b1011);
      tick();
      a_pix_valid = 1'b0;
      check("t2_accept_ready", 32'(a_pix_ready), 0);
      check("t2_first_bit",    32'(a_ser_d), 1);
      wait_ready(1'b0);
      check("t2_latency",  w_cyc, 10);
      check("t2_hi_cycles", w_hi, 4);
      check("t2_hi_run",   w_hmax, 1);
      check("t2_latch_len", w_lat, 1);
      check("t2_row",      32'(a_row_addr), 1);
      check("t2_n_oe",     32'(a_n_oe), 0);
      check("t2_chain",    32'(chain_a), 32'(4'b1011));

      // ---- 3: divider, CLK_DIV=3
      b_pix_data = 4'b0110; b_pix_valid = 1'b1;
      tick();
      b_pix_valid = 1'b0;
      check("t3_accept_ready", 32'(b_pix_ready), 0);
      check("t3_first_bit",    32'(b_ser_d), 0);
      wait_ready(1'b1);
      check("t3_latency",   w_cyc, 28);
      check("t3_hi_cycles", w_hi, 12);
      check("t3_hi_min",    w_hmin, 3);
      check("t3_hi_max",    w_hmax, 3);
      check("t3_latch_len", w_lat, 3);
      check("t3_row",       32'(b_row_addr), 1);
      check("t3_chain",     32'(chain_b), 32'(4'b0110));

      // ---- 4: frame wrap, back-to-back
      CLR = 1'b0;
      tick();
      CLR = 1'b1;
      tick();
      check("t4_ready", 32'(a_pix_ready), 1);
      check("t4_row0",  32'(a_row_addr), 0);
      a_pix_valid = 1'b1; a_pix_data = 4'h3; q_a.push_back(4'h3);
      for (int k = 0; k < 8; k++) begin
         tick();
         check("t4_accept_ready", 32'(a_pix_ready), 0);
         if (k < 7) begin
            a_pix_data = 4'(4'h3 + 4'(3 * (k + 1)));
            q_a.push_back(a_pix_data);
         end else begin
            a_pix_valid = 1'b0;
         end
         wait_ready(1'b0);
         check("t4_latency", w_cyc, 10);
         check("t4_row", 32'(a_row_addr), (k + 1) % 8);
         check("t4_fs_count", w_fs, (k == 7) ? 1 : 0);
         if (k >= 1) check("t4_blank_len", w_noe, 2);
      end
      check("t4_fs_wrap", 32'(a_frame_start), 1);
      tick();
      check("t4_fs_after", 32'(a_frame_start), 0);
      check("t4_idle_ready", 32'(a_pix_ready), 1);

      // ---- 5: handshake hold-off during SHIFT
      a_pix_data = 4'b1001; a_pix_valid = 1'b1; q_a.push_back(4'b1001);
      tick();
      a_pix_valid = 1'b0;
      check("t5_accept_ready", 32'(a_pix_ready), 0);
      tick(); tick();
      a_pix_data = 4'b0110; a_pix_valid = 1'b1;
      tick();
      check("t5_holdoff_ready", 32'(a_pix_ready), 0);
      a_pix_valid = 1'b0;
      tick();
      a_pix_data = 4'b0011; a_pix_valid = 1'b1; q_a.push_back(4'b0011);
      wait_ready(1'b0);
      check("t5_latency", w_cyc + 4, 10);
      check("t5_row1", 32'(a_row_addr), 1);
      tick();
      a_pix_valid = 1'b0;
      check("t5_held_accept", 32'(a_pix_ready), 0);
      check("t5_held_bit",    32'(a_ser_d), 0);
      wait_ready(1'b0);
      check("t5_row2", 32'(a_row_addr), 2);

      // ---- 6: reset mid-SHIFT
      a_pix_data = 4'b0111; a_pix_valid = 1'b1; q_a.push_back(4'b0111);
      tick();
      a_pix_valid = 1'b0;
      cnt = 0; prev = 1'b0;
      while (cnt < 2 && w_cyc < 1000) begin
         tick();
         w_cyc++;
         if (a_ser_clk && !prev) cnt++;
         prev = a_ser_clk;
      end
      check("t6_second_pulse", cnt, 2);
      CLR = 1'b0;
      #1;
      q_a.delete();
      check("t6_ser_clk", 32'(a_ser_clk), 0);
      check("t6_ser_d",   32'(a_ser_d), 0);
      check("t6_latch",   32'(a_latch), 0);
      check("t6_n_oe",    32'(a_n_oe), 1);
      check("t6_row",     32'(a_row_addr), 0);
      check("t6_ready",   32'(a_pix_ready), 0);
      tick();
      CLR = 1'b1;
      tick();
      check("t6_rel_ready", 32'(a_pix_ready), 1);
      a_pix_data = 4'b1111; a_pix_valid = 1'b1; q_a.push_back(4'b1111);
      tick();
      a_pix_valid = 1'b0;
      wait_ready(1'b0);
      check("t6_latency", w_cyc, 10);
      check("t6_row1",    32'(a_row_addr), 1);
      check("t6_n_oe_on", 32'(a_n_oe), 0);
      check("t6_chain",   32'(chain_a), 32'(4'b1111));

      repeat (2) tick();
      check("sb_drained", q_a.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/led_row_shift_driver.md
Name: led_row_shift_driver

Overview:
Upstream driver for the panel's serial column chain of D flip-flops. Accepts one parallel row word per handshake and serialises it MSB-first onto ser_d with a generated shift clock. It then blanks the panel, pulses the latch and advances the row address. It sits between the frame-buffer reader and the modelled flip-flop/shift-register column chain.

Parameters:
COLS, 16, bits per row word; number of shift-clock pulses per row (>=2)
ROWS, 8, rows scanned per frame; row_addr wraps at ROWS-1 (>=2)
CLK_DIV, 2, clk cycles per ser_clk half-period and latch pulse length (>=1)

Ports:
clk  in  1  system clock, all state on rising edge
CLR  in  1  reset, asynchronous, active-low
pix_data  in  COLS  row word, bit COLS-1 shifted first
pix_valid  in  1  producer has a word; held until accepted
pix_ready  out  1  driver idle and can accept a word
ser_d  out  1  serial data to chain D input
ser_clk  out  1  shift clock to chain
latch  out  1  storage-register latch strobe, active high
n_oe  out  1  panel output enable, active low (1 = blanked)
row_addr  out  max(1,$clog2(ROWS))  row currently displayed
frame_start  out  1  one-cycle pulse when row_addr wraps to 0

Behaviour:
- Reset (CLR=0, async, immediate): state IDLE, pix_ready=0, ser_d=0, ser_clk=0, latch=0, n_oe=1, row_addr=0, frame_start=0, shift register and counters cleared. An in-flight word is discarded.
- First clk edge after CLR release: pix_ready goes to 1. n_oe stays 1 until the first row is latched.
- All outputs are registered. No combinational path from inputs to outputs.
- States: IDLE, SHIFT, BLANK, LATCH.
- IDLE: pix_ready=1, ser_clk=0, latch=0.
- IDLE, transfer: a transfer occurs on an edge with pix_valid=1 and pix_ready=1. On that edge the word is captured, pix_ready goes to 0, ser_d takes pix_data[COLS-1], and the state moves to SHIFT.
- SHIFT: each bit is a low phase of CLK_DIV cycles (ser_clk=0) followed by a high phase of CLK_DIV cycles (ser_clk=1). ser_d changes only on the edge that starts a low phase, so ser_d is stable for CLK_DIV cycles before and during the ser_clk rising edge. There are COLS bits, MSB first. A bit counter and a divider counter track progress.
- SHIFT exit: after the final high phase, the state moves to BLANK, with ser_clk=0, ser_d=0 and n_oe=1.
- BLANK: lasts 1 cycle, then the state moves to LATCH.
- LATCH: latch=1 for CLK_DIV cycles with n_oe held 1.
- LATCH exit edge, all on the same edge: latch=0, n_oe=0, row_addr increments (ROWS-1 wraps to 0), pix_ready=1, and the state returns to IDLE.
- frame_start is 1 for exactly the cycle after the edge where row_addr wraps to 0. Otherwise it is 0.
- Latency: from the accept edge to pix_ready re-asserted is 2*CLK_DIV*COLS + 1 + CLK_DIV cycles.
- n_oe stays 0 through IDLE and the next SHIFT, so the previously latched row displays while the next row shifts. n_oe=1 only in BLANK and LATCH.
- pix_valid and pix_data are ignored while pix_ready=0. There is no overflow or error condition.
- Back-to-back operation: if pix_valid=1 on the first IDLE cycle, the next transfer occurs on that edge and IDLE lasts exactly 1 cycle.
- Reset asserted mid-SHIFT or mid-LATCH: outputs return to reset values immediately. The row is not latched and row_addr returns to 0.

Test Plan:
1. Reset/idle: hold CLR=0, toggle clk -> ser_clk=0, latch=0, n_oe=1, row_addr=0, pix_ready=0. Release CLR -> pix_ready=1 after 1 edge. n_oe stays 1 with no word offered.
2. Single row (COLS=4, CLK_DIV=1): offer 4'b1011 -> ser_d sequence 1,0,1,1, each stable at 4 ser_clk rising edges. Then BLANK 1 cycle, latch high 1 cycle. pix_ready returns 10 cycles after accept, n_oe=0, row_addr=1. Capture ser_d on ser_clk rise into a SN74LS74 chain and check q values match.
3. Divider (COLS=4, CLK_DIV=3): offer 4'b0110 -> each ser_clk half-period is 3 cycles, latch is high 3 cycles, and pix_ready returns after 2*3*4+1+3=28 cycles.
4. Frame wrap (ROWS=8): stream 8 words back-to-back with pix_valid held 1 -> row_addr steps 1..7,0 and frame_start pulses exactly once, 1 cycle, after the 8th latch. IDLE lasts 1 cycle between rows.
5. Handshake hold-off: change pix_data and pulse pix_valid during SHIFT -> no effect on the ser_d sequence. A word held valid is accepted only on the IDLE edge.
6. Mid-operation reset: assert CLR after the 2nd ser_clk pulse -> outputs return to reset values immediately. After release, a new word 4'b1111 shifts cleanly and row_addr=1 after its latch.
